// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings and display-mask constants for the MM:SS clock mode controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_PAUSE   = 2'd1,
    MODE_ADJ_MIN = 2'd2,
    MODE_ADJ_SEC = 2'd3
  } mode_t;

  // Digit order: [3] min_ten, [2] min_one, [1] sec_ten, [0] sec_one
  localparam logic [3:0] MASK_ALL = 4'b1111;
  localparam logic [3:0] MASK_MIN = 4'b1100;
  localparam logic [3:0] MASK_SEC = 4'b0011;

endpackage

// File: rtl/btn_repeat.sv
// Button front end: registers a debounced level, detects its rise and, when enabled,
// re-issues a press every REPEAT_CYC cycles while the button stays held.
module btn_repeat #(
  parameter int REPEAT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  input  logic rpt_en_i,
  input  logic rpt_clr_i,
  output logic press_o
);

  localparam int RW = $clog2(REPEAT_CYC);

  logic          btn_q;
  logic          prev_q;
  logic [RW-1:0] rpt_q;
  logic [RW-1:0] rpt_d;
  logic          rise;
  logic          held;
  logic          rpt_hit;

  // Sample and history both reset high so a button held through reset is not a press.
  // NOTE: sequential state uses non-blocking assignments so every register sees the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q  <= 1'b1;
      prev_q <= 1'b1;
      rpt_q  <= '0;
    end else begin
      btn_q  <= btn_i;
      prev_q <= btn_q;
      rpt_q  <= rpt_d;
    end
  end

  assign rise    = btn_q & ~prev_q;
  assign held    = btn_q & prev_q;
  assign rpt_hit = held & rpt_en_i & (rpt_q == RW'(REPEAT_CYC - 1));

  // NOTE: rpt_d gets a default before any condition so no latch can be inferred.
  always_comb begin
    rpt_d = '0;
    if (held && rpt_en_i && !rpt_clr_i && !rpt_hit) begin
      rpt_d = rpt_q + 1'b1;
    end
  end

  assign press_o = rise | rpt_hit;

endmodule

// File: rtl/clock_mode_ctrl.sv
// RUN/PAUSE/ADJ_MIN/ADJ_SEC sequencer with 1 Hz prescaler for the MM:SS counter.
// Define CLOCK_BLINK_EN to blink the field being adjusted; otherwise digit_mask is all-on.
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
`ifdef CLOCK_BLINK_EN
  parameter int BLINK_CYC  = 25_000_000,
`endif
  parameter int REPEAT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       btn_sel,
  input  logic       btn_adj,
  input  logic       btn_clr,
  output logic       cnt_en,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       cnt_clr,
  output logic [1:0] mode,
  output logic [3:0] digit_mask
);

  localparam int PW = $clog2(CLK_HZ);

  logic pause_p, sel_p, adj_p, clr_p;
  logic in_adj, mode_chg, tick;

  mode_t         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cnt_en_q, inc_sec_q, inc_min_q, cnt_clr_q;
  logic          inc_sec_d, inc_min_d, cnt_clr_d;

  assign in_adj   = (mode_q == MODE_ADJ_MIN) || (mode_q == MODE_ADJ_SEC);
  assign mode_chg = (mode_d != mode_q);

  btn_repeat #(.REPEAT_CYC(REPEAT_CYC)) u_pause (
    .clk(clk), .reset(reset), .btn_i(btn_pause),
    .rpt_en_i(1'b0), .rpt_clr_i(1'b0), .press_o(pause_p)
  );
  btn_repeat #(.REPEAT_CYC(REPEAT_CYC)) u_sel (
    .clk(clk), .reset(reset), .btn_i(btn_sel),
    .rpt_en_i(1'b0), .rpt_clr_i(1'b0), .press_o(sel_p)
  );
  btn_repeat #(.REPEAT_CYC(REPEAT_CYC)) u_adj (
    .clk(clk), .reset(reset), .btn_i(btn_adj),
    .rpt_en_i(in_adj), .rpt_clr_i(mode_chg), .press_o(adj_p)
  );
  btn_repeat #(.REPEAT_CYC(REPEAT_CYC)) u_clr (
    .clk(clk), .reset(reset), .btn_i(btn_clr),
    .rpt_en_i(1'b0), .rpt_clr_i(1'b0), .press_o(clr_p)
  );

  // One event per cycle, priority sel > pause > clr > adj.
  always_comb begin
    mode_d    = mode_q;
    inc_sec_d = 1'b0;
    inc_min_d = 1'b0;
    cnt_clr_d = 1'b0;
    unique case (mode_q)
      MODE_RUN: begin
        if (sel_p)        mode_d = MODE_ADJ_MIN;
        else if (pause_p) mode_d = MODE_PAUSE;
      end
      MODE_PAUSE: begin
        if (sel_p)        mode_d    = MODE_ADJ_MIN;
        else if (pause_p) mode_d    = MODE_RUN;
        else if (clr_p)   cnt_clr_d = 1'b1;
      end
      MODE_ADJ_MIN: begin
        if (sel_p)        mode_d    = MODE_ADJ_SEC;
        else if (adj_p)   inc_min_d = 1'b1;
      end
      MODE_ADJ_SEC: begin
        if (sel_p)        mode_d    = MODE_RUN;
        else if (adj_p)   inc_sec_d = 1'b1;
      end
    endcase
  end

  // A tick due in the same cycle as leaving RUN is still emitted.
  assign tick = (mode_q == MODE_RUN) && (presc_q == PW'(CLK_HZ - 1));

  always_comb begin
    presc_d = '0;
    if ((mode_q == MODE_RUN) && (mode_d == MODE_RUN) && !tick) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_PAUSE;
      presc_q   <= '0;
      cnt_en_q  <= 1'b0;
      inc_sec_q <= 1'b0;
      inc_min_q <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      cnt_en_q  <= tick;
      inc_sec_q <= inc_sec_d;
      inc_min_q <= inc_min_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  assign cnt_en  = cnt_en_q;
  assign inc_sec = inc_sec_q;
  assign inc_min = inc_min_q;
  assign cnt_clr = cnt_clr_q;
  assign mode    = mode_q;

`ifdef CLOCK_BLINK_EN
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  logic          blank_q, blank_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [3:0]    mask_q, mask_d;

  // Phase restarts "shown" on any mode entry and on every increment pulse.
  always_comb begin
    blank_d = 1'b0;
    blink_d = '0;
    mask_d  = MASK_ALL;
    if (((mode_d == MODE_ADJ_MIN) || (mode_d == MODE_ADJ_SEC)) &&
        !mode_chg && !inc_min_d && !inc_sec_d) begin
      if (blink_q == BW'(BLINK_CYC - 1)) begin
        blank_d = ~blank_q;
      end else begin
        blank_d = blank_q;
        blink_d = blink_q + 1'b1;
      end
    end
    if (blank_d) begin
      mask_d = (mode_d == MODE_ADJ_MIN) ? ~MASK_MIN : ~MASK_SEC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q <= 1'b0;
      blink_q <= '0;
      mask_q  <= MASK_ALL;
    end else begin
      blank_q <= blank_d;
      blink_q <= blink_d;
      mask_q  <= mask_d;
    end
  end

  assign digit_mask = mask_q;
`else
  assign digit_mask = MASK_ALL;
`endif

endmodule
